// File: rtl/mat_pkg.sv
// Shared defaults, controller state encoding and saturation limits for
// the row-serial matrix-add datapath.
package mat_pkg;

    localparam int DEF_DATA_LEN = 32;
    localparam int DEF_K        = 8;
    localparam int DEF_M        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Signed clamp limits at the default element width
    localparam logic [DEF_DATA_LEN-1:0] SAT_MAX = {1'b0, {(DEF_DATA_LEN-1){1'b1}}};
    localparam logic [DEF_DATA_LEN-1:0] SAT_MIN = {1'b1, {(DEF_DATA_LEN-1){1'b0}}};

endpackage

// File: rtl/mat_row_add.sv
// Combinational K-lane signed row adder with optional saturation and a
// per-lane overflow flag.
module mat_row_add
    import mat_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int K        = DEF_K,
    parameter int SATURATE = 0
) (
    input  logic [DATA_LEN*K-1:0] a,
    input  logic [DATA_LEN*K-1:0] b,
    output logic [DATA_LEN*K-1:0] sum,
    output logic [K-1:0]          ovf
);

    localparam logic [DATA_LEN-1:0] LANE_MAX = {1'b0, {(DATA_LEN-1){1'b1}}};
    localparam logic [DATA_LEN-1:0] LANE_MIN = {1'b1, {(DATA_LEN-1){1'b0}}};

    for (genvar i = 0; i < K; i++) begin : g_lane
        logic [DATA_LEN-1:0] ae;
        logic [DATA_LEN-1:0] be;
        logic [DATA_LEN-1:0] s;

        assign ae = a[DATA_LEN*i +: DATA_LEN];
        assign be = b[DATA_LEN*i +: DATA_LEN];
        assign s  = ae + be;

        // Overflow: operands agree in sign but the wrapped sum does not
        assign ovf[i] = (ae[DATA_LEN-1] == be[DATA_LEN-1]) &&
                        (s[DATA_LEN-1] != ae[DATA_LEN-1]);

        assign sum[DATA_LEN*i +: DATA_LEN] =
            ((SATURATE != 0) && ovf[i]) ? (ae[DATA_LEN-1] ? LANE_MIN : LANE_MAX) : s;
    end

endmodule

// File: rtl/mat_add_seq_ctrl.sv
// Row-serial sequencer: joins A/B row streams, adds them lane-wise and
// emits registered result rows with a last-row tag, busy/done/overflow.
module mat_add_seq_ctrl
    import mat_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int K        = DEF_K,
    parameter int M        = DEF_M,
    parameter int SATURATE = 0,
    parameter int ROW_SIZE = DATA_LEN * K,
    parameter int IDX_W    = (M > 1) ? $clog2(M) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_ovf,
    input  logic                i_a_valid,
    input  logic [ROW_SIZE-1:0] i_a_row,
    output logic                o_a_ready,
    input  logic                i_b_valid,
    input  logic [ROW_SIZE-1:0] i_b_row,
    output logic                o_b_ready,
    output logic                o_c_valid,
    output logic [ROW_SIZE-1:0] o_c_row,
    output logic                o_c_last,
    input  logic                i_c_ready,
    output logic [IDX_W-1:0]    o_row_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

    state_t              state;
    logic                slot_free;
    logic                fire;
    logic                c_hs;
    logic                is_last_idx;
    logic [ROW_SIZE-1:0] sum_row;
    logic [K-1:0]        lane_ovf;

    mat_row_add #(
        .DATA_LEN (DATA_LEN),
        .K        (K),
        .SATURATE (SATURATE)
    ) u_row_add (
        .a   (i_a_row),
        .b   (i_b_row),
        .sum (sum_row),
        .ovf (lane_ovf)
    );

    // Join both streams only when the output register can take a new row
    always_comb begin
        slot_free   = !o_c_valid || i_c_ready;
        fire        = (state == RUN) && i_a_valid && i_b_valid && slot_free;
        c_hs        = o_c_valid && i_c_ready;
        is_last_idx = (o_row_idx == LAST_IDX);
        o_a_ready   = fire;
        o_b_ready   = fire;
    end

    // Controller state, output row register and status flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_ovf     <= 1'b0;
            o_c_valid <= 1'b0;
            o_c_row   <= '0;
            o_c_last  <= 1'b0;
            o_row_idx <= '0;
        end else begin
            o_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= RUN;
                        o_busy    <= 1'b1;
                        o_ovf     <= 1'b0;
                        o_row_idx <= '0;
                    end
                end
                RUN: begin
                    if (fire && is_last_idx) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (c_hs && o_c_last) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase

            if (fire) begin
                o_c_row   <= sum_row;
                o_c_valid <= 1'b1;
                o_c_last  <= is_last_idx;
                o_row_idx <= is_last_idx ? '0 : o_row_idx + 1'b1;
                if (|lane_ovf) begin
                    o_ovf <= 1'b1;
                end
            end else if (c_hs) begin
                o_c_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mat_add_seq_ctrl.md
Name: mat_add_seq_ctrl

Overview:
Row-serial sequencer for the matrix-add datapath. On a start command it joins two row streams (A, B) of one M x K matrix pair, one ROW_SIZE-bit row per handshake. It adds each pair lane-wise through a K-lane row adder and emits the sum rows on a registered valid/ready output stream, tagging the last row. It sits between the operand row buffers and the result writeback, and reports busy, done and a sticky overflow flag.

Parameters:
DATA_LEN, 32, bits per signed element
K, 8, elements per row (lanes)
M, 8, rows per matrix (transfers per operation)
SATURATE, 0, 0 = two's-complement wrap on overflow; 1 = clamp to signed min/max
ROW_SIZE, DATA_LEN*K, bits per row bus (derived)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous active-high reset
i_start  in  1  start one M-row operation; honoured only in IDLE
o_busy  out  1  high in RUN or DRAIN
o_done  out  1  one-cycle pulse after the last output row handshake
o_ovf  out  1  sticky: any lane of any row overflowed in current/last op; cleared on accepted start
i_a_valid  in  1  A row valid
i_a_row  in  ROW_SIZE  A row, element i at [DATA_LEN*i +: DATA_LEN]
o_a_ready  out  1  A row consumed this cycle
i_b_valid  in  1  B row valid
i_b_row  in  ROW_SIZE  B row, same packing
o_b_ready  out  1  B row consumed this cycle
o_c_valid  out  1  result row valid (registered)
o_c_row  out  ROW_SIZE  result row, same packing (registered)
o_c_last  out  1  qualifies row M-1 of the result (registered)
i_c_ready  in  1  downstream accepts result row
o_row_idx  out  clog2(M)  index of next A/B row to be accepted

Behaviour:
- Reset (i_rst=1 at edge): state IDLE, o_busy=0, o_done=0, o_ovf=0, o_c_valid=0, o_c_row=0, o_c_last=0, o_row_idx=0. Reset mid-operation abandons the op; any pending result row is dropped.
- States: IDLE -> RUN on i_start; RUN -> DRAIN when row M-1 is accepted; DRAIN -> IDLE on the output handshake with o_c_last=1. i_start is ignored in RUN and DRAIN.
- Output slot free: slot_free = !o_c_valid || i_c_ready.
- Join: fire = (state==RUN) && i_a_valid && i_b_valid && slot_free. o_a_ready = o_b_ready = fire. The two streams are never consumed independently. Ready may depend on valid. Valid must not depend on ready.
- Latency: 1 cycle. On fire, o_c_row <= A+B lane-wise, o_c_valid <= 1, o_c_last <= (o_row_idx==M-1), o_row_idx increments and wraps to 0 after M-1.
- On an output handshake without fire, o_c_valid <= 0. Fire and output handshake in the same cycle gives back-to-back rows: full throughput, one row per cycle.
- Output stability: while o_c_valid && !i_c_ready, o_c_row and o_c_last hold.
- Arithmetic: signed DATA_LEN + DATA_LEN per lane. Lane overflow = operands same sign and result sign differs.
  - SATURATE=0: wrapped result.
  - SATURATE=1: clamp to 2^(DATA_LEN-1)-1 or -2^(DATA_LEN-1).
  - Any lane overflow on fire sets o_ovf.
- o_done: registered pulse in the cycle after the last-row handshake. State is already IDLE, so i_start is accepted in that same cycle. On start, o_ovf clears and o_row_idx=0.
- M=1: the first fire goes straight to DRAIN with o_c_last=1.

Decomposition:
- Package mat_pkg:
  - DATA_LEN/K/M defaults
  - state enum (IDLE=0, RUN=1, DRAIN=2)
  - SAT_MAX/SAT_MIN constants as functions of DATA_LEN
- Sub-module mat_row_add: combinational K-lane signed adder, parameters DATA_LEN, K, SATURATE. Outputs the sum row and a K-bit per-lane overflow vector. The controller ORs that vector into o_ovf.

Test Plan:
- Basic: start, A row r lane i = r*8+i, B = 100, i_c_ready=1 always -> 8 rows out back-to-back, first 1 cycle after first fire. Row r lane i = r*8+i+100. o_c_last only on row 7. o_done one cycle after row 7 handshake.
- Backpressure: i_c_ready low for 3 cycles on row 2 -> o_c_row/o_c_last held stable, o_a_ready=o_b_ready=0 during the stall, no row lost or duplicated.
- Join skew: B valid delayed 4 cycles relative to A -> no fire until both valid; A row held; output equals A+B per row.
- Overflow: lane 0 = 0x7FFFFFFF + 1. SATURATE=0 gives 0x80000000, SATURATE=1 gives 0x7FFFFFFF; o_ovf=1 in both. The next start clears it. -1 + -1 = -2 with no overflow.
- Start handling: start pulsed during RUN ignored (row count unchanged). Start in the o_done cycle accepted -> new op begins, o_row_idx=0.
- Reset mid-op: i_rst after 3 rows with o_c_valid=1 -> next cycle o_c_valid=0, o_busy=0, o_row_idx=0. A fresh op completes correctly.
